// File: rtl/softmax_pkg.sv
// Shared float width, zero constant and FSM state encodings for the accumulator
// and its float adder.
package softmax_pkg;

    localparam int unsigned FLOAT_W = 32;
    localparam logic [FLOAT_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        GET_TERM,
        ADD_REQ,
        ADD_WAIT,
        PUT_Z
    } acc_state_t;

    typedef enum logic {
        ADD_GET,
        ADD_PUT
    } add_state_t;

endpackage

// File: rtl/adder.sv
// IEEE-754 single-precision adder behind stb/ack handshakes on a, b and z.
// Round-to-nearest-even with denormal support; NaN results are canonical 7fc00000.
module adder
    import softmax_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] input_a,
    input  logic               input_a_stb,
    output logic               input_a_ack,
    input  logic [FLOAT_W-1:0] input_b,
    input  logic               input_b_stb,
    output logic               input_b_ack,
    output logic [FLOAT_W-1:0] output_z,
    output logic               output_z_stb,
    input  logic               output_z_ack
);

    add_state_t         state_q, state_d;
    logic               have_a_q, have_a_d, have_b_q, have_b_d;
    logic [FLOAT_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

    // Aligned add on 24-bit significands plus guard, round and sticky bits.
    function automatic logic [FLOAT_W-1:0] fp_add(input logic [FLOAT_W-1:0] a,
                                                  input logic [FLOAT_W-1:0] b);
        logic [FLOAT_W-1:0] x, y, r;
        logic [9:0]         ex, ey, e, diff;
        logic [26:0]        mx, my;
        logic [27:0]        s;
        logic [24:0]        mr;
        logic               sticky, rnd, nan_a, nan_b, inf_a, inf_b;
        nan_a = (a[30:23] == 8'hff) && (a[22:0] != '0);
        nan_b = (b[30:23] == 8'hff) && (b[22:0] != '0);
        inf_a = (a[30:23] == 8'hff) && (a[22:0] == '0);
        inf_b = (b[30:23] == 8'hff) && (b[22:0] == '0);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex   = (x[30:23] == '0) ? 10'd1 : {2'b00, x[30:23]};
        ey   = (y[30:23] == '0) ? 10'd1 : {2'b00, y[30:23]};
        mx   = {x[30:23] != '0, x[22:0], 3'b000};
        my   = {y[30:23] != '0, y[22:0], 3'b000};
        diff = ex - ey;
        if (diff > 10'd26) begin
            sticky = (my != '0);
            my     = '0;
        end else begin
            sticky = (my & ~(27'h7ff_ffff << diff)) != '0;
            my     = my >> diff;
        end
        my[0] = my[0] | sticky;
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        e = ex;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && (e > 10'd1)) begin
                s = s << 1;
                e = e - 10'd1;
            end
        end
        rnd = s[2] && (s[1] || s[0] || s[3]);
        mr  = {1'b0, s[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) r = 32'h7fc0_0000;
        else if (inf_a)            r = a;
        else if (inf_b)            r = b;
        else if (s == '0)          r = {a[31] & b[31], 31'd0};
        else if (e >= 10'd255)     r = {x[31], 8'hff, 23'd0};
        else                       r = {x[31], mr[23] ? e[7:0] : 8'h00, mr[22:0]};
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        have_a_d = have_a_q;
        have_b_d = have_b_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        case (state_q)
            ADD_GET: begin
                if (input_a_stb && a_ack_q) begin
                    a_d      = input_a;
                    have_a_d = 1'b1;
                end
                if (input_b_stb && b_ack_q) begin
                    b_d      = input_b;
                    have_b_d = 1'b1;
                end
                if (have_a_q && have_b_q) begin
                    z_d      = fp_add(a_q, b_q);
                    have_a_d = 1'b0;
                    have_b_d = 1'b0;
                    state_d  = ADD_PUT;
                end
            end
            ADD_PUT: begin
                if (output_z_ack && z_stb_q) state_d = ADD_GET;
            end
            default: state_d = ADD_GET;
        endcase
        a_ack_d = (state_d == ADD_GET) && !have_a_d;
        b_ack_d = (state_d == ADD_GET) && !have_b_d;
        z_stb_d = (state_d == ADD_PUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ADD_GET;
            have_a_q <= 1'b0;
            have_b_q <= 1'b0;
            a_q      <= FP_ZERO;
            b_q      <= FP_ZERO;
            z_q      <= FP_ZERO;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            z_stb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            have_a_q <= have_a_d;
            have_b_q <= have_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            z_stb_q  <= z_stb_d;
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: rtl/float_accumulator.sv
// Sums N_TERMS float32 terms through the handshaked float adder and presents
// the total on a stb/ack output with strict back-pressure.
module float_accumulator
    import softmax_pkg::*;
#(
    parameter int unsigned N_TERMS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] input_a,
    input  logic               input_a_stb,
    output logic               input_a_ack,
    output logic [FLOAT_W-1:0] output_z,
    output logic               output_z_stb,
    input  logic               output_z_ack
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

    acc_state_t         state_q, state_d;
    logic [FLOAT_W-1:0] sum_q, sum_d, term_q, term_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ack_q, in_ack_d, z_stb_q, z_stb_d;
    logic               add_a_stb_q, add_a_stb_d, add_b_stb_q, add_b_stb_d;
    logic               add_z_ack_q, add_z_ack_d;
    logic               add_a_ack, add_b_ack, add_z_stb;
    logic [FLOAT_W-1:0] add_z;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        term_d      = term_q;
        cnt_d       = cnt_q;
        add_a_stb_d = add_a_stb_q;
        add_b_stb_d = add_b_stb_q;
        case (state_q)
            GET_TERM: begin
                if (input_a_stb && in_ack_q) begin
                    term_d      = input_a;
                    add_a_stb_d = 1'b1;
                    add_b_stb_d = 1'b1;
                    state_d     = ADD_REQ;
                end
            end
            ADD_REQ: begin
                // Each adder input completes on its own; move on once both have.
                if (add_a_stb_q && add_a_ack) add_a_stb_d = 1'b0;
                if (add_b_stb_q && add_b_ack) add_b_stb_d = 1'b0;
                if (!add_a_stb_d && !add_b_stb_d) state_d = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (add_z_stb && add_z_ack_q) begin
                    sum_d   = add_z;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == CNT_W'(N_TERMS)) ? PUT_Z : GET_TERM;
                end
            end
            PUT_Z: begin
                if (output_z_ack && z_stb_q) begin
                    sum_d   = FP_ZERO;
                    cnt_d   = '0;
                    state_d = GET_TERM;
                end
            end
            default: state_d = GET_TERM;
        endcase
        in_ack_d    = (state_d == GET_TERM);
        add_z_ack_d = (state_d == ADD_WAIT);
        z_stb_d     = (state_d == PUT_Z);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= GET_TERM;
            sum_q       <= FP_ZERO;
            term_q      <= FP_ZERO;
            cnt_q       <= '0;
            in_ack_q    <= 1'b0;
            z_stb_q     <= 1'b0;
            add_a_stb_q <= 1'b0;
            add_b_stb_q <= 1'b0;
            add_z_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            term_q      <= term_d;
            cnt_q       <= cnt_d;
            in_ack_q    <= in_ack_d;
            z_stb_q     <= z_stb_d;
            add_a_stb_q <= add_a_stb_d;
            add_b_stb_q <= add_b_stb_d;
            add_z_ack_q <= add_z_ack_d;
        end
    end

    adder u_adder (
        .clk          (clk),
        .rst          (~rst),
        .input_a      (sum_q),
        .input_a_stb  (add_a_stb_q),
        .input_a_ack  (add_a_ack),
        .input_b      (term_q),
        .input_b_stb  (add_b_stb_q),
        .input_b_ack  (add_b_ack),
        .output_z     (add_z),
        .output_z_stb (add_z_stb),
        .output_z_ack (add_z_ack_q)
    );

    assign input_a_ack  = in_ack_q;
    assign output_z     = sum_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_float_accumulator.sv
// Self-checking bench: three accumulators (N_TERMS 4, 2, 1) driven from a vector
// table and hand sequences; a scoreboard queue holds expected sums per output.
module tb_float_accumulator;

    localparam int unsigned NI = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NI-1:0][31:0]    in_a;
    logic [NI-1:0][31:0]    z;
    logic [NI-1:0]          in_stb, in_ack, z_stb, z_ack;

    float_accumulator #(.N_TERMS(4)) dut4 (
        .clk(clk), .rst(rst), .input_a(in_a[0]), .input_a_stb(in_stb[0]), .input_a_ack(in_ack[0]),
        .output_z(z[0]), .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0]));
    float_accumulator #(.N_TERMS(2)) dut2 (
        .clk(clk), .rst(rst), .input_a(in_a[1]), .input_a_stb(in_stb[1]), .input_a_ack(in_ack[1]),
        .output_z(z[1]), .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1]));
    float_accumulator #(.N_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .input_a(in_a[2]), .input_a_stb(in_stb[2]), .input_a_ack(in_ack[2]),
        .output_z(z[2]), .output_z_stb(z_stb[2]), .output_z_ack(z_ack[2]));

    always #5 clk = ~clk;

    typedef struct {
        int unsigned k;
        logic [31:0] v;
    } exp_t;

    typedef struct {
        int unsigned k;
        int unsigned n;
        logic [31:0] t [4];
        logic [31:0] expv;
    } vec_t;

    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [14];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called right after a rising edge; returns right after the edge that took the term.
    task automatic send(input int unsigned k, input logic [31:0] v);
        int n = 0;
        in_a[k]   = v;
        in_stb[k] = 1'b1;
        @(negedge clk);
        while (!in_ack[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ack[k]) begin
            checks++;
            failures++;
            $display("FAIL send_timeout inst=%0d actual=ack_low required=ack_high", k);
        end
        @(posedge clk);
        #1;
        in_stb[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int unsigned k, input int unsigned n,
                           input logic [31:0] t0, input logic [31:0] t1,
                           input logic [31:0] t2, input logic [31:0] t3, input logic [31:0] e);
        vecs[i].k    = k;
        vecs[i].n    = n;
        vecs[i].t[0] = t0;
        vecs[i].t[1] = t1;
        vecs[i].t[2] = t2;
        vecs[i].t[3] = t3;
        vecs[i].expv = e;
    endtask

    // Exact conversion for normal values that fit in single precision.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Output monitor: a result seen with stb&ack transfers on the next rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst && z_stb[k] && z_ack[k]) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output inst=%0d actual=%08h required=none", k, z[k]);
                end else begin
                    mon_e = sb.pop_front();
                    check("output_inst", 32'(k), 32'(mon_e.k));
                    check("output_z", z[k], mon_e.v);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        real         acc;
        real         tv [4];
        int unsigned n;

        rst    = 1'b0;
        in_a   = '0;
        in_stb = '0;
        z_ack  = '1;

        set_vec(0,  0, 4, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h40800000);
        set_vec(1,  1, 2, 32'h3e19999a, 32'hbe19999a, 32'h0, 32'h0, 32'h00000000);
        set_vec(2,  1, 2, 32'h3f800000, 32'h3f800000, 32'h0, 32'h0, 32'h40000000);
        set_vec(3,  1, 2, 32'h40000000, 32'h40000000, 32'h0, 32'h0, 32'h40800000);
        set_vec(4,  2, 1, 32'h3e19999a, 32'h0, 32'h0, 32'h0, 32'h3e19999a);
        set_vec(5,  2, 1, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h00000000);
        set_vec(6,  2, 1, 32'h7f800000, 32'h0, 32'h0, 32'h0, 32'h7f800000);
        set_vec(7,  0, 4, 32'h3f800000, 32'hbf800000, 32'h3fc00000, 32'h40200000, 32'h40800000);
        set_vec(8,  1, 2, 32'h7f7fffff, 32'h7f7fffff, 32'h0, 32'h0, 32'h7f800000);
        set_vec(9,  1, 2, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 32'h00000002);
        set_vec(10, 1, 2, 32'h3f800000, 32'h33800000, 32'h0, 32'h0, 32'h3f800000);
        set_vec(11, 1, 2, 32'h3f800000, 32'h33800001, 32'h0, 32'h0, 32'h3f800001);
        set_vec(12, 2, 1, 32'h7fc00000, 32'h0, 32'h0, 32'h0, 32'h7fc00000);
        set_vec(13, 1, 2, 32'hff800000, 32'h7f800000, 32'h0, 32'h0, 32'h7fc00000);

        // Reset state, then input_a_ack rising one edge after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_in_ack", 32'(in_ack[k]), 32'd0);
            check("reset_z_stb", 32'(z_stb[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ack_before_first_edge", 32'(in_ack[0]), 32'd0);
        @(negedge clk);
        check("ack_after_reset", 32'(in_ack[0]), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            sb.push_back('{k: vecs[i].k, v: vecs[i].expv});
            for (int j = 0; j < int'(vecs[i].n); j++) send(vecs[i].k, vecs[i].t[j]);
            drain();
        end

        // Output stall: result held stable, no term accepted.
        z_ack[1] = 1'b0;
        sb.push_back('{k: 1, v: 32'h3f800000});
        send(1, 32'h3f000000);
        send(1, 32'h3f000000);
        n = 0;
        @(negedge clk);
        while (!z_stb[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            check("stall_z_stb", 32'(z_stb[1]), 32'd1);
            check("stall_z", z[1], 32'h3f800000);
            check("stall_in_ack", 32'(in_ack[1]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        z_ack[1] = 1'b1;
        drain();
        check("z_stb_drops", 32'(z_stb[1]), 32'd0);

        // Reset mid-accumulation discards the partial sum and in-flight add.
        send(0, 32'h3f800000);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("midreset_in_ack", 32'(in_ack[0]), 32'd0);
        check("midreset_z_stb", 32'(z_stb[0]), 32'd0);
        rst = 1'b1;
        for (int j = 0; j < 3; j++) send(0, 32'h3f000000);
        tick(8);
        check("no_early_output", 32'(z_stb[0]), 32'd0);
        sb.push_back('{k: 0, v: 32'h40000000});
        send(0, 32'h3f000000);
        drain();

        // Random gaps between terms against a real-valued reference sum.
        for (int g = 0; g < 8; g++) begin
            acc = 0.0;
            for (int j = 0; j < 4; j++) begin
                tv[j] = 0.5 * real'($urandom_range(1, 8));
                if ($urandom_range(0, 1) == 1) tv[j] = -tv[j];
                acc += tv[j];
            end
            sb.push_back('{k: 0, v: r2f(acc)});
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                send(0, r2f(tv[j]));
            end
            drain();
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_accumulator.md
FLOAT_ACCUMULATOR -- requirements
Module: float_accumulator

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, meaning the number of float32 terms summed per result (legal range 1..1023).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-004 The block SHALL have port input_a, input, 32, the IEEE-754 single-precision term.
REQ-005 The block SHALL have port input_a_stb, input, 1, meaning the term is valid.
REQ-006 The block SHALL have port input_a_ack, output, 1, meaning the block accepts the term.
REQ-007 The block SHALL have port output_z, output, 32, the float32 sum of N_TERMS accepted terms.
REQ-008 The block SHALL have port output_z_stb, output, 1, meaning output_z is valid.
REQ-009 The block SHALL have port output_z_ack, input, 1, meaning the consumer takes output_z.

Function
REQ-010 A transfer SHALL occur on any rising edge where stb and ack are both high; stb SHALL hold and data SHALL stay stable until that edge.
REQ-011 The FSM SHALL have states GET_TERM, ADD_REQ, ADD_WAIT and PUT_Z, and leave reset in GET_TERM.
REQ-012 In GET_TERM, input_a_ack SHALL be 1; on transfer, the term SHALL be latched and the FSM SHALL go to ADD_REQ.
REQ-013 input_a_ack SHALL be 0 in every state except GET_TERM, including the cycle after a transfer.
REQ-014 In ADD_REQ, the block SHALL drive the adder with a = running sum and b = latched term.
REQ-015 In ADD_REQ, the block SHALL assert each adder input strobe separately until that input's ack is seen, then drop that strobe.
REQ-016 When both adder acks have been seen, the FSM SHALL go to ADD_WAIT.
REQ-017 In ADD_WAIT, the block SHALL assert the adder output_z_ack; when the adder output_z_stb is seen, it SHALL load the sum and increment the term counter.
REQ-018 After that load, the FSM SHALL go to PUT_Z if the counter equals N_TERMS, else to GET_TERM.
REQ-019 In PUT_Z, output_z_stb SHALL be 1 with output_z = sum, held indefinitely while output_z_ack = 0.
REQ-020 On the PUT_Z transfer, the sum SHALL clear to 32'h00000000, the counter SHALL clear to 0, and the FSM SHALL go to GET_TERM; output_z_stb SHALL drop the next cycle.
REQ-021 No term SHALL be accepted while in PUT_Z, i.e. strict back-pressure.
REQ-022 The term counter SHALL be $clog2(N_TERMS+1) bits wide and SHALL never exceed N_TERMS.
REQ-023 For N_TERMS = 1, the result SHALL be 0 + x as computed by the adder.
REQ-024 Arithmetic, rounding and special values (NaN, Inf, denormal) SHALL be exactly as the adder produces; the block itself SHALL perform no float arithmetic.
REQ-025 Latency SHALL be 1 cycle of input accept, plus the adder latency for each term, plus 1 cycle to PUT_Z.
REQ-026 output_z SHALL be stable whenever output_z_stb = 1.

Reset
REQ-027 On rst = 0 at a rising edge, the block SHALL force: state = GET_TERM, sum = 0, counter = 0, output_z_stb = 0, input_a_ack = 0, adder strobes = 0, adder output_z_ack = 0.
REQ-028 input_a_ack SHALL rise in the first cycle after rst returns to 1.
REQ-029 The adder instance SHALL receive ~rst, so it is reset in the same cycle.
REQ-030 A reset mid-accumulation SHALL discard the partial sum and any in-flight adder operation; no stale result SHALL appear afterward.

Structure
REQ-031 Package softmax_pkg SHALL hold FLOAT_W = 32, FP_ZERO = 32'h00000000 and the accumulator state enum.
REQ-032 The block SHALL contain exactly one sub-module: the existing float adder, named adder and instanced as u_adder.
REQ-033 All sequencing SHALL live in float_accumulator, with one registered FSM; outputs SHALL be registered or decoded from state only.

Verification
REQ-034 N_TERMS = 4, terms 3f800000 x4 with stb held -> exactly one output_z = 40800000 (4.0).
REQ-035 N_TERMS = 2, terms 3e19999a, be19999a -> output_z = 00000000.
REQ-036 N_TERMS = 2, terms 3f000000, 3f000000 with output_z_ack low for 5 cycles -> output_z = 3f800000 held stable, and input_a_ack = 0 throughout the stall.
REQ-037 Two back-to-back groups, N_TERMS = 2: {3f800000, 3f800000}, then {40000000, 40000000} -> outputs 40000000, then 40800000, proving the sum clears between groups.
REQ-038 rst = 0 for 1 cycle after 1 term of 4 (3f800000), then 4 terms of 3f000000 -> output_z = 40000000, with no output before the 4th post-reset term.
REQ-039 Random stb gaps on input_a_stb -> no term is lost or duplicated, checked against a reference sum model.
